// File: rtl/burst_channel_pkg.sv
// Shared types and constants for the burst error-injection channel.
// Mode and FSM encodings, LFSR polynomial taps and the default seed.
package burst_channel_pkg;

  typedef enum logic [1:0] {
    MODE_OFF      = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_RANDOM   = 2'd2,
    MODE_BURST    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/burst_channel_lfsr16.sv
// 16-bit Galois LFSR that steps once per adv pulse.
// An all-zero seed would lock up, so it is replaced by 1 on reset.
module lfsr16
  import burst_channel_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  input  logic [15:0] seed,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else if (adv) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/burst_channel.sv
// Channel model that corrupts code symbols by XOR with a mask, in one of
// four modes, over a finite window of accepted symbols.
//
//   state    | meaning
//   ST_IDLE  | no burst in progress; a trigger may start one (BURST mode)
//   ST_BURST | corrupting the remaining rem symbols of a burst
//   ST_DONE  | window exhausted; everything passes clean until clear/reset
module burst_channel
  import burst_channel_pkg::*;
#(
  parameter int          W      = 2,
  parameter int          N      = 4,
  parameter int          PLOG   = 5,
  parameter int          WINDOW = 256,
  parameter int          CW     = 16,
  parameter logic [15:0] SEED   = DEFAULT_SEED
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_i,
  input  logic          valid_i,
  input  logic [W-1:0]  sym_i,
  input  logic [1:0]    mode_i,
  input  logic [3:0]    burst_len_i,
  input  logic [W-1:0]  mask_i,
  output logic          valid_o,
  output logic [W-1:0]  sym_o,
  output logic [W-1:0]  flip_o,
  output logic [CW-1:0] sym_ct_o,
  output logic [CW-1:0] err_bit_ct_o,
  output logic          done_o
);

  localparam int            PERIOD    = 1 << PLOG;
  localparam logic [CW-1:0] WIN_CT    = CW'(WINDOW);
  localparam logic [CW-1:0] WIN_LAST  = CW'(WINDOW - 1);
  localparam logic [15:0]   TRIG_MASK = 16'((1 << N) - 1);

  state_e        state;
  logic [3:0]    rem;
  logic [15:0]   lfsr;
  logic          accept;
  logic          trigger;
  logic          eligible;
  logic          in_tail;
  logic [W-1:0]  flip;
  logic [CW-1:0] pop;
  logic [CW:0]   err_sum;

  // Cleared symbols are not accepted, so they never step the LFSR.
  assign accept = valid_i & ~clear_i;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv   (accept),
    .seed  (SEED),
    .state (lfsr)
  );

  assign trigger  = ((lfsr & TRIG_MASK) == 16'h0000);
  assign eligible = accept && (sym_ct_o < WIN_CT) && (burst_len_i != 4'd0)
                    && (state != ST_DONE);
  assign in_tail  = (32'(sym_ct_o[PLOG-1:0]) + 32'(burst_len_i)) >= 32'(PERIOD);

  always_comb begin
    flip = '0;
    if (eligible) begin
      case (mode_i)
        MODE_PERIODIC: if (in_tail) flip = mask_i;
        MODE_RANDOM:   if (trigger) flip = mask_i;
        MODE_BURST:    if (state == ST_BURST || trigger) flip = mask_i;
        default:       flip = '0;
      endcase
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < W; i++) begin
      pop = pop + CW'(flip[i]);
    end
  end

  assign err_sum = {1'b0, err_bit_ct_o} + {1'b0, pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o      <= 1'b0;
      sym_o        <= '0;
      flip_o       <= '0;
      sym_ct_o     <= '0;
      err_bit_ct_o <= '0;
      done_o       <= 1'b0;
      state        <= ST_IDLE;
      rem          <= '0;
    end else begin
      valid_o <= valid_i;
      sym_o   <= valid_i ? (sym_i ^ flip) : '0;
      flip_o  <= flip;
      if (clear_i) begin
        sym_ct_o     <= '0;
        err_bit_ct_o <= '0;
        done_o       <= 1'b0;
        state        <= ST_IDLE;
        rem          <= '0;
      end else if (valid_i) begin
        err_bit_ct_o <= err_sum[CW] ? '1 : err_sum[CW-1:0];
        if (sym_ct_o < WIN_CT) sym_ct_o <= sym_ct_o + CW'(1);
        // The last window symbol drops any burst still in flight.
        if (sym_ct_o == WIN_LAST) begin
          done_o <= 1'b1;
          state  <= ST_DONE;
          rem    <= '0;
        end else begin
          case (state)
            ST_IDLE: begin
              if (eligible && mode_i == MODE_BURST && trigger && burst_len_i > 4'd1) begin
                state <= ST_BURST;
                rem   <= burst_len_i - 4'd1;
              end
            end
            ST_BURST: begin
              if (!eligible || mode_i != MODE_BURST || rem == 4'd1) begin
                state <= ST_IDLE;
                rem   <= '0;
              end else begin
                rem <= rem - 4'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: doc/burst_channel.md
BURST_CHANNEL -- requirements
Module: burst_channel

Interface
REQ-001 The block SHALL have parameters: W, default 2, code-symbol width in bits.
REQ-002 The block SHALL have parameter N, default 4, random error rate exponent (probability 2^-N per symbol).
REQ-003 The block SHALL have parameter PLOG, default 5, periodic-mode period of 2^PLOG symbols.
REQ-004 The block SHALL have parameter WINDOW, default 256, number of symbols eligible for injection.
REQ-005 The block SHALL have parameter CW, default 16, counter width.
REQ-006 The block SHALL have parameter SEED, default 16'hACE1, LFSR reset value.
REQ-007 The block SHALL have these ports (name direction width meaning):
- clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- clear_i  in  1  restarts the window and counters.
- valid_i  in  1  sym_i valid this cycle.
- sym_i  in  W  encoder output symbol.
- mode_i  in  2  0=OFF, 1=PERIODIC, 2=RANDOM, 3=BURST.
- burst_len_i  in  4  burst length in symbols; 0 disables injection.
- mask_i  in  W  bits to invert on a corrupted symbol.
- valid_o  out  1  sym_o valid.
- sym_o  out  W  channel output symbol.
- flip_o  out  W  mask actually applied to sym_o.
- sym_ct_o  out  CW  valid symbols accepted in the window.
- err_bit_ct_o  out  CW  inverted bits injected.
- done_o  out  1  window exhausted; sticky.

Function
REQ-008 Latency SHALL be exactly 1 cycle: valid_o, sym_o and flip_o are registered versions of valid_i, sym_i^flip and flip.
REQ-009 When valid_i=0 the block SHALL drive valid_o=0 and flip_o=0, and SHALL hold the LFSR, FSM and counters.
REQ-010 The LFSR SHALL be a 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) that advances once per accepted valid symbol; a trigger SHALL fire when lfsr[N-1:0]==0, evaluated before the advance.
REQ-011 A symbol SHALL be eligible for corruption only if sym_ct_o < WINDOW and burst_len_i != 0.
REQ-012 In OFF mode, flip SHALL be 0.
REQ-013 In PERIODIC mode, flip SHALL equal mask_i when sym_ct_o[PLOG-1:0] >= 2^PLOG - burst_len_i, i.e. the last burst_len_i symbols of each period are corrupted.
REQ-014 In RANDOM mode, flip SHALL equal mask_i on each trigger, with symbols independent of one another.
REQ-015 BURST mode SHALL be controlled by an FSM with states IDLE, BURST and DONE:
- IDLE, trigger: corrupt this symbol; if burst_len_i>1, load rem=burst_len_i-1 and go to BURST.
- BURST: corrupt each valid symbol and decrement rem; return to IDLE after the symbol that takes rem to 0.
- A trigger in BURST SHALL NOT extend the burst.
- A mode_i change away from BURST in BURST state SHALL abort to IDLE, and that symbol SHALL follow the new mode.
REQ-016 sym_ct_o SHALL increment per valid symbol and saturate at WINDOW; on reaching WINDOW the FSM SHALL enter DONE and done_o SHALL assert on the same cycle as the count update.
REQ-017 In DONE (any mode) symbols SHALL pass uncorrupted, and an in-progress burst truncated by the window end SHALL be dropped.
REQ-018 err_bit_ct_o SHALL add popcount(flip) per corrupted symbol and saturate at 2^CW-1.
REQ-019 clear_i SHALL zero sym_ct_o and err_bit_ct_o, deassert done_o, and return the FSM to IDLE, without reseeding the LFSR.
REQ-020 clear_i together with valid_i SHALL take priority: the symbol passes clean and is not counted.

Reset
REQ-021 On rst=1 at a clk edge the block SHALL set valid_o=0, sym_o=0, flip_o=0, sym_ct_o=0, err_bit_ct_o=0, done_o=0, FSM=IDLE, rem=0 and LFSR=SEED (SEED=0 SHALL be replaced by 1).
REQ-022 Reset mid-burst SHALL discard the burst, and the first valid after reset release SHALL be treated as symbol 0.

Structure
REQ-023 A package burst_channel_pkg SHALL hold the mode enum, the FSM state enum, the LFSR tap constant 16'hB400 and the default SEED.
REQ-024 The LFSR SHALL be a sub-module lfsr16 (ports clk, rst, adv, seed, state).

Verification
REQ-025 The bench SHALL cover PERIODIC with burst_len=3, mask=2'b11 and 256 continuous valids: symbols 29-31 of every 32 are inverted; err_bit_ct_o=48; done_o rises on the 256th symbol.
REQ-026 The bench SHALL cover RANDOM with N=4 over 4096 symbols (WINDOW=4096): the flip pattern matches a reference LFSR model bit-exactly, with a count near 256 corrupted symbols.
REQ-027 The bench SHALL cover BURST with burst_len=5, forcing a trigger then a second trigger at rem=2: exactly 5 consecutive symbols are corrupted, with no extension.
REQ-028 The bench SHALL cover valid_i gaps (1-0-0-1 pattern) in PERIODIC: the LFSR, counters and burst position are unchanged across gaps, and valid_o=0 with flip_o=0 in the gaps.
REQ-029 The bench SHALL cover clear_i and valid_i together at sym_ct=100, then rst during a BURST: counters read 0, the cleared symbol passes clean, and after reset the outputs match REQ-021 with the LFSR at SEED.
REQ-030 The bench SHALL cover mode change BURST->OFF at rem=3 and burst_len_i=0 in PERIODIC: the burst aborts immediately, and no corruption occurs with burst_len_i=0.
